// File: rtl/xor_nibble_descrambler.sv
// xor_nibble_descrambler
// Receive-side nibble descrambler. It regenerates the sender's keystream
// with a 4-bit Fibonacci LFSR (x^4+x^3+1, period 15), seeded from `key`.
// It XORs the keystream out of each accepted nibble and delivers the
// plaintext through a one-entry output register with ready/valid handshakes.
// `out_inv` is the bitwise complement of the output register.
//
// Optional build macro: DESCR_PARITY_EN
//   When defined, the block adds input `in_par`, which carries even parity
//   over the plaintext, and output `par_err`, which is registered alongside
//   `out_data` and flags a parity mismatch for the held word.
//   When undefined, these ports and the parity logic are not present.

module xor_nibble_descrambler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_load,
  input  logic [3:0]       key,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
`ifdef DESCR_PARITY_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [3:0]       out_inv,
  output logic [CNT_W-1:0] beat_cnt
);

  // NOKEY: no keystream seed yet, input is refused.
  // RUN: a key has been loaded at least once since reset.
  typedef enum logic {
    NOKEY = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state_reg;
  logic [3:0]       ks_reg;
  logic [3:0]       ks_next;
  logic [3:0]       seed_next;
  logic [3:0]       plain_next;
  logic [3:0]       out_data_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic             accept;
  logic             drain;

  // Derive the seed, the next LFSR step and the recovered nibble.
  // An all-zero seed would lock the LFSR, so it is replaced by 0001.
  always_comb begin
    seed_next  = (key == 4'b0000) ? 4'b0001 : key;
    ks_next    = {ks_reg[2:0], ks_reg[3] ^ ks_reg[2]};
    plain_next = in_data ^ ks_reg;
  end

  // Space is available when a key is present, no reseed is in progress, and
  // the output register is empty or is draining this cycle. in_valid is
  // deliberately absent from this expression.
  assign in_ready = (state_reg == RUN) && !key_load && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_reg && out_ready;

  // Run the key FSM, the LFSR, the beat counter and the output register.
  // A reseed leaves any pending output untouched: that word was decoded
  // with the old keystream and drains normally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= NOKEY;
      ks_reg        <= 4'b0001;
      beat_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 4'b0000;
    end else begin
      case (state_reg)
        NOKEY: begin
          if (key_load) begin
            state_reg    <= RUN;
            ks_reg       <= seed_next;
            beat_cnt_reg <= '0;
          end
        end
        RUN: begin
          if (key_load) begin
            ks_reg       <= seed_next;
            beat_cnt_reg <= '0;
          end else if (accept) begin
            ks_reg       <= ks_next;
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= NOKEY;
        end
      endcase

      // A new beat replaces a draining beat in the same cycle, so out_valid
      // stays high and the block sustains one beat per cycle.
      if (accept) begin
        out_data_reg  <= plain_next;
        out_valid_reg <= 1'b1;
      end else if (drain) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef DESCR_PARITY_EN
  logic par_err_reg;

  // Register the parity check with the data word, so the same hold rules apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_reg <= 1'b0;
    end else if (accept) begin
      par_err_reg <= (^plain_next) != in_par;
    end
  end

  assign par_err = par_err_reg;
`endif

  // The complement comes straight from the output register, one bit per lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_inv
      assign out_inv[gi] = ~out_data_reg[gi];
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign beat_cnt  = beat_cnt_reg;

endmodule

// File: tb/tb_xor_nibble_descrambler.sv
// Testbench for xor_nibble_descrambler: scoreboard queue plus monitor,
// directed scenarios followed by randomized traffic.
// Build with +define+DESCR_PARITY_EN to exercise the parity option.

module tb_xor_nibble_descrambler;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             key_load = 1'b0;
  logic [3:0]       key = 4'b0000;
  logic             in_valid = 1'b0;
  logic [3:0]       in_data = 4'b0000;
  logic             in_ready;
  logic             in_par = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_data;
  logic [3:0]       out_inv;
  logic [CNT_W-1:0] beat_cnt;
`ifdef DESCR_PARITY_EN
  logic             par_err;
`endif

  always #5 clk = ~clk;

  xor_nibble_descrambler #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_load (key_load),
    .key      (key),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
`ifdef DESCR_PARITY_EN
    .in_par   (in_par),
    .par_err  (par_err),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_inv  (out_inv),
    .beat_cnt (beat_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] data;
    logic       perr;
  } exp_t;
  exp_t sb_q[$];

  // The maximal-length keystream of x^4+x^3+1, listed once starting at 0001.
  // The model tracks a position in this cycle instead of shifting bits.
  logic [3:0] ks_tab [15];
  bit         m_run = 1'b0;
  bit         m_ov  = 1'b0;
  int         m_pos = 0;
  int         m_cnt = 0;
  bit         armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int seed_pos(input logic [3:0] k);
    logic [3:0] s;
    s = (k == 4'b0000) ? 4'b0001 : k;
    for (int i = 0; i < 15; i++)
      if (ks_tab[i] == s) return i;
    return 0;
  endfunction

  // Monitor: any word the DUT presents must match the head of the
  // scoreboard. It is popped when the consumer takes it, and it must hold
  // while the consumer stalls.
  always @(negedge clk) begin
    logic [3:0] inv_e;
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got out_valid=1 expected no pending word at %0t", $time);
      end else begin
        inv_e = ~sb_q[0].data;
        chk("out_data", out_data, sb_q[0].data);
        chk("out_inv", out_inv, inv_e);
`ifdef DESCR_PARITY_EN
        chk("par_err", par_err, sb_q[0].perr);
`endif
        if (out_ready === 1'b1) void'(sb_q.pop_front());
      end
    end
  end

  // One clock cycle: drive the inputs, check the handshake and the counter
  // mid-cycle, then advance the model at the clock edge.
  task automatic step(input logic kl, input logic [3:0] k, input logic iv,
                      input logic [3:0] d, input logic p, input logic ordy);
    bit   m_rdy, acc, drn;
    exp_t e;
    key_load  = kl;
    key       = k;
    in_valid  = iv;
    in_data   = d;
    in_par    = p;
    out_ready = ordy;
    @(negedge clk);
    m_rdy = m_run && !kl && (!m_ov || ordy);
    if (armed) begin
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_ov);
      chk("beat_cnt", beat_cnt, m_cnt);
    end
    @(posedge clk);
    if (reset) begin
      m_run = 1'b0;
      m_ov  = 1'b0;
      m_pos = 0;
      m_cnt = 0;
      sb_q.delete();
    end else begin
      acc = iv && m_rdy;
      drn = m_ov && ordy;
      if (kl) begin
        m_run = 1'b1;
        m_pos = seed_pos(k);
        m_cnt = 0;
      end
      if (acc) begin
        e.data = d ^ ks_tab[m_pos];
        e.perr = (^e.data) != p;
        sb_q.push_back(e);
        m_pos = (m_pos + 1) % 15;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_ov  = 1'b1;
      end else if (drn) begin
        m_ov = 1'b0;
      end
    end
    armed = 1'b1;
    #1;
  endtask

  logic [3:0] seq [16];

  initial begin
    ks_tab[0]  = 4'b0001; ks_tab[1]  = 4'b0010; ks_tab[2]  = 4'b0100;
    ks_tab[3]  = 4'b1001; ks_tab[4]  = 4'b0011; ks_tab[5]  = 4'b0110;
    ks_tab[6]  = 4'b1101; ks_tab[7]  = 4'b1010; ks_tab[8]  = 4'b0101;
    ks_tab[9]  = 4'b1011; ks_tab[10] = 4'b0111; ks_tab[11] = 4'b1111;
    ks_tab[12] = 4'b1110; ks_tab[13] = 4'b1100; ks_tab[14] = 4'b1000;

    // Reset state
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("rst_out_data", out_data, 4'b0000);
    chk("rst_out_inv", out_inv, 4'b1111);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_in_ready", in_ready, 1'b0);

    // Input is refused while no key is loaded
    step(0, 0, 1, 4'b0101, 0, 1);
    step(0, 0, 1, 4'b0101, 0, 1);
    chk("nokey_out_valid", out_valid, 1'b0);
    chk("nokey_beat_cnt", beat_cnt, 0);

    // Key 0110: back-to-back beats
    step(1, 4'b0110, 1, 4'b0101, 0, 1);
    step(0, 0, 1, 4'b0101, 0, 1);
    chk("k6_first", out_data, 4'b0011);
    chk("k6_first_inv", out_inv, 4'b1100);
    step(0, 0, 1, 4'b1101, 0, 1);
    chk("k6_second", out_data, 4'b0000);
    chk("k6_second_inv", out_inv, 4'b1111);
    chk("k6_beat_cnt", beat_cnt, 2);

    // A zero key is forced to seed 0001
    step(1, 4'b0000, 0, 0, 0, 1);
    step(0, 0, 1, 4'b0001, 0, 1);
    chk("zero_seed", out_data, 4'b0000);

    // Backpressure: the word is held and the input is refused, then accepted
    // in the same cycle in which the consumer drains.
    step(1, 4'b0110, 0, 0, 0, 1);
    step(0, 0, 1, 4'b0101, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 4'b1101, 0, 0);
      chk("stall_hold", out_data, 4'b0011);
    end
    chk("stall_in_ready", in_ready, 1'b0);
    step(0, 0, 1, 4'b1101, 0, 1);
    chk("stall_release", out_data, 4'b0000);
    chk("stall_beat_cnt", beat_cnt, 2);

    // Period of 15, then a reseed in mid-stream
    step(1, 4'b1001, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 4'b0000, 0, 1);
      seq[i] = out_data;
    end
    chk("period_15", seq[15], seq[0]);
    chk("period_first", seq[0], 4'b1001);
    step(1, 4'b0011, 0, 0, 0, 1);
    chk("reseed_cnt", beat_cnt, 0);
    step(0, 0, 1, 4'b0000, 0, 1);
    chk("reseed_data", out_data, 4'b0011);

    // Reset in mid-stream discards the pending word
    step(0, 0, 1, 4'b0111, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    step(0, 0, 1, 4'b0101, 0, 1);
    chk("midrst_nokey", out_valid, 1'b0);

`ifdef DESCR_PARITY_EN
    step(1, 4'b0110, 0, 0, 0, 1);
    step(0, 0, 1, 4'b0101, 1, 1);
    chk("par_bad", par_err, 1'b1);
    step(1, 4'b0110, 0, 0, 0, 1);
    step(0, 0, 1, 4'b0101, 0, 1);
    chk("par_good", par_err, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      step(($urandom_range(0, 15) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
           4'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
